// File: rtl/spike_raster_pkg.sv
// spike_raster_pkg: shared types, sizing helpers and Gray-code conversions for the spike raster pipe
`timescale 1ns/1ps
package spike_raster_pkg;
  localparam int FN_W = 32;
  localparam int WORD_W = 16;
  typedef enum logic [1:0] {IDLE, CAPTURE, SKIP} wr_state_t;
  function automatic int wpf(input int nn);
    return (1 << (nn + 1)) / WORD_W;
  endfunction
  function automatic int ptr_width(input int depth_log2);
    return depth_log2 + 1;
  endfunction
  function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
    logic [FN_W-1:0] b;
    b[FN_W-1] = g[FN_W-1];
    for (int i = FN_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/spike_raster_pipe_gray_ptr_sync.sv
// gray_ptr_sync: 2-FF synchronizer for a Gray-coded pointer, delivering the binary value
`timescale 1ns/1ps
module gray_ptr_sync
  import spike_raster_pkg::*;
#(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset_global,
  input  logic [W-1:0] gray_in,
  output logic [W-1:0] bin_out
);
  logic [W-1:0] meta, sync;
  always_ff @(posedge clk or posedge reset_global)
    if (reset_global) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= gray_in;
      sync <= meta;
    end
  assign bin_out = W'(gray2bin(32'(sync)));
endmodule

// File: rtl/spike_raster_pipe.sv
// spike_raster_pipe: packs per-slot spike bits into 16-bit words and buffers whole frames across neuron_clk -> ti_clk
`timescale 1ns/1ps
module spike_raster_pipe
  import spike_raster_pkg::*;
#(
  parameter int NN = 8,
  parameter int DEPTH_LOG2 = 10,
  parameter int BLOCK_WORDS = 256
) (
  input  logic        neuron_clk,
  input  logic        ti_clk,
  input  logic        reset_global,
  input  logic        capture_en,
  input  logic        slot_valid,
  input  logic [NN:0] slot_index,
  input  logic        spike,
  input  logic        ep_read,
  output logic        ep_ready,
  output logic [15:0] ep_datain,
  output logic [15:0] frames_dropped,
  output logic        underflow
);
  localparam int PW = ptr_width(DEPTH_LOG2);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int WPF = wpf(NN);
  logic [15:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, wr_gray, rd_ptr_w, used_w, free_w;
  logic [PW-1:0] rd_ptr, rd_gray, wr_ptr_r, rd_ptr_nxt;
  logic [15:0] shift_word, word_next;
  wr_state_t state, state_nxt, state_eff;
  logic frame_start, frame_end, admit, cap_slot, push, drop;
  logic empty_r, ready_r, rd_en;
  assign frame_start = slot_valid && slot_index == '0;
  assign frame_end = slot_valid && slot_index == '1;
  assign used_w = wr_ptr - rd_ptr_w;
  assign free_w = PW'(DEPTH) - used_w;
  assign admit = free_w >= PW'(WPF);
  always_ff @(posedge neuron_clk or posedge reset_global)
    if (reset_global) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = frame_start ? (capture_en ? (admit ? CAPTURE : SKIP) : IDLE)
              : frame_end ? IDLE : state;
  // The frame-start strobe already belongs to the frame being entered.
  always_comb begin
    state_eff = frame_start ? state_nxt : state;
    cap_slot = slot_valid && state_eff == CAPTURE;
    push = cap_slot && slot_index[3:0] == 4'hF;
    drop = frame_start && capture_en && !admit;
  end
  always_comb begin
    word_next = shift_word;
    word_next[slot_index[3:0]] = spike;
  end
  always_ff @(posedge neuron_clk or posedge reset_global)
    if (reset_global) begin
      shift_word <= '0;
      wr_ptr <= '0;
      wr_gray <= '0;
      frames_dropped <= '0;
    end else begin
      if (cap_slot) shift_word <= push ? '0 : word_next;
      wr_ptr <= wr_ptr + PW'(push);
      wr_gray <= PW'(bin2gray(32'(wr_ptr + PW'(push))));
      if (drop && frames_dropped != 16'hFFFF) frames_dropped <= frames_dropped + 16'd1;
    end
  always_ff @(posedge neuron_clk)
    if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= word_next;
  gray_ptr_sync #(.W(PW)) u_rd2wr (
    .clk(neuron_clk),
    .reset_global(reset_global),
    .gray_in(rd_gray),
    .bin_out(rd_ptr_w)
  );
  gray_ptr_sync #(.W(PW)) u_wr2rd (
    .clk(ti_clk),
    .reset_global(reset_global),
    .gray_in(wr_gray),
    .bin_out(wr_ptr_r)
  );
  assign rd_en = ep_read && !empty_r;
  assign rd_ptr_nxt = rd_ptr + PW'(rd_en);
  // Empty tracks the post-read pointer so FWFT never overruns; ready lags one read.
  always_ff @(posedge ti_clk or posedge reset_global)
    if (reset_global) begin
      rd_ptr <= '0;
      rd_gray <= '0;
      empty_r <= 1'b1;
      ready_r <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      rd_gray <= PW'(bin2gray(32'(rd_ptr_nxt)));
      empty_r <= wr_ptr_r == rd_ptr_nxt;
      ready_r <= (wr_ptr_r - rd_ptr) >= PW'(BLOCK_WORDS);
      if (ep_read && empty_r) underflow <= 1'b1;
    end
  assign ep_ready = ready_r;
  assign ep_datain = empty_r ? 16'h0000 : mem[rd_ptr[DEPTH_LOG2-1:0]];
endmodule

// File: tb/tb_spike_raster_pipe.sv
// tb_spike_raster_pipe: scoreboard bench for the spike raster pipe
`timescale 1ns/1ps
module tb_spike_raster_pipe;
  logic neuron_clk = 0, ti_clk = 0, reset_global = 1;
  logic capture_en = 0, slot_valid = 0, spike = 0, ep_read = 0;
  logic [8:0] slot_index = '0;
  logic ep_ready, underflow;
  logic [15:0] ep_datain, frames_dropped;
  int n_cmp = 0, n_bad = 0, exp_drop = 0, n;
  logic [15:0] sb[$];
  logic [511:0] pat, pat5;
  always #5 neuron_clk = ~neuron_clk;
  always #10.417 ti_clk = ~ti_clk;
  spike_raster_pipe dut (
    .neuron_clk(neuron_clk),
    .ti_clk(ti_clk),
    .reset_global(reset_global),
    .capture_en(capture_en),
    .slot_valid(slot_valid),
    .slot_index(slot_index),
    .spike(spike),
    .ep_read(ep_read),
    .ep_ready(ep_ready),
    .ep_datain(ep_datain),
    .frames_dropped(frames_dropped),
    .underflow(underflow)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic rand_pat(output logic [511:0] p);
    for (int i = 0; i < 16; i++) p[32*i +: 32] = $urandom;
  endtask
  task automatic send_frame(input logic [511:0] sp, input int drop_at);
    for (int i = 0; i < 512; i++) begin
      @(negedge neuron_clk);
      if (i == drop_at) capture_en = 0;
      if (i == 0 && capture_en) begin
        if (1024 - sb.size() >= 32) for (int k = 0; k < 32; k++) sb.push_back(sp[16*k +: 16]);
        else exp_drop++;
      end
      slot_valid = 1;
      slot_index = 9'(i);
      spike = sp[i];
    end
    @(negedge neuron_clk);
    slot_valid = 0;
    spike = 0;
  endtask
  task automatic read_word(input string tag);
    logic [15:0] exp;
    @(negedge ti_clk);
    exp = 16'h0;
    if (sb.size() > 0) exp = sb.pop_front();
    check(tag, ep_datain, exp);
    ep_read = 1;
    @(posedge ti_clk);
    #1 ep_read = 0;
  endtask
  task automatic wait_ready(input string tag, input int limit, output int cnt);
    cnt = 0;
    while (!ep_ready && cnt < limit) begin
      @(posedge ti_clk);
      #1 cnt++;
    end
    check(tag, ep_ready, 1);
  endtask
  task automatic settle;
    repeat (8) @(negedge ti_clk);
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge neuron_clk);
    check("rst_ready", ep_ready, 0);
    check("rst_data", ep_datain, 0);
    check("rst_dropped", frames_dropped, 0);
    check("rst_underflow", underflow, 0);
    reset_global = 0;
    capture_en = 1;
    pat = '0;
    pat[0] = 1;
    pat[17] = 1;
    pat[511] = 1;
    send_frame(pat, -1);
    settle();
    for (int i = 0; i < 32; i++) read_word("t1_word");
    settle();
    check("t1_empty_data", ep_datain, 0);
    for (int f = 0; f < 7; f++) begin
      rand_pat(pat);
      send_frame(pat, -1);
    end
    settle();
    check("t2_ready_224", ep_ready, 0);
    rand_pat(pat);
    send_frame(pat, -1);
    wait_ready("t2_ready_rise", 4, n);
    check("t2_ready_latency", n <= 3, 1);
    for (int i = 0; i < 256; i++) read_word("t2_word");
    settle();
    check("t2_ready_fall", ep_ready, 0);
    for (int f = 0; f < 32; f++) begin
      rand_pat(pat);
      send_frame(pat, -1);
    end
    settle();
    check("t3_ready_full", ep_ready, 1);
    for (int i = 0; i < 24; i++) read_word("t3_word");
    settle();
    rand_pat(pat);
    send_frame(pat, -1);
    check("t3_dropped", frames_dropped, 16'(exp_drop));
    check("t3_dropped_one", frames_dropped, 1);
    for (int i = 0; i < 8; i++) read_word("t3_word");
    settle();
    rand_pat(pat);
    send_frame(pat, -1);
    check("t3_admitted", frames_dropped, 1);
    settle();
    for (int i = 0; i < 1100 && sb.size() > 0; i++) read_word("t3_drain");
    settle();
    check("t3_empty_data", ep_datain, 0);
    check("t3_ready_low", ep_ready, 0);
    capture_en = 1;
    rand_pat(pat);
    send_frame(pat, 100);
    rand_pat(pat);
    send_frame(pat, -1);
    settle();
    for (int i = 0; i < 32; i++) read_word("t4_word");
    settle();
    check("t4_no_extra", ep_datain, 0);
    check("t4_ready_low", ep_ready, 0);
    capture_en = 1;
    fork
      for (int f = 0; f < 40; f++) begin
        rand_pat(pat5);
        send_frame(pat5, -1);
      end
      for (int b = 0; b < 5; b++) begin
        int m;
        wait_ready("t5_ready", 3000, m);
        for (int i = 0; i < 256; i++) read_word("t5_word");
        repeat (2) @(negedge ti_clk);
      end
    join
    settle();
    check("t5_no_drops", frames_dropped, 16'(exp_drop));
    check("t5_underflow_clear", underflow, 0);
    check("t5_empty_data", ep_datain, 0);
    @(negedge ti_clk);
    ep_read = 1;
    @(posedge ti_clk);
    #1 ep_read = 0;
    @(negedge ti_clk);
    check("t6_underflow", underflow, 1);
    check("t6_data_zero", ep_datain, 0);
    rand_pat(pat);
    send_frame(pat, -1);
    settle();
    for (int i = 0; i < 32; i++) read_word("t6_word");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
